// File: rtl/maze_mem_arbiter.sv
// maze_mem_arbiter
//
// Arbitrates the single-port maze memory (one bit per maze cell) between the
// host loader and the solver controller, and contains a clear engine that
// zeroes every cell. This is the only driver of the memory pins.
//
// Ports:
//   clk, rst                  system clock, synchronous active-low reset
//   hReq/hWr/hAddr/hDin       host request (level, held until hAck)
//   hAck/hDout                host completion pulse and read data
//   sReq/sWr/sAddr/sDin       solver request, same protocol as host
//   sAck/sDout                solver completion pulse and read data
//   clr                       one-cycle pulse requesting a full clear
//   clrBusy/clrDone           clear pending-or-running / last-cell pulse
//   memLoc/memRd/memWr/memDin memory address, strobes, write data
//   memDout                   memory read data, valid the cycle after memRd
//
// One access takes three cycles: IDLE (grant + latch), ACCESS (strobe),
// RESP (ack + read data). On contention a round-robin pointer alternates.

module maze_mem_arbiter #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              hReq,
  input  logic              hWr,
  input  logic [ADDR_W-1:0] hAddr,
  input  logic              hDin,
  output logic              hAck,
  output logic              hDout,

  input  logic              sReq,
  input  logic              sWr,
  input  logic [ADDR_W-1:0] sAddr,
  input  logic              sDin,
  output logic              sAck,
  output logic              sDout,

  input  logic              clr,
  output logic              clrBusy,
  output logic              clrDone,

  output logic [ADDR_W-1:0] memLoc,
  output logic              memRd,
  output logic              memWr,
  output logic              memDin,
  input  logic              memDout
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp,
    StClear
  } state_e;

  localparam logic [ADDR_W-1:0] CntLast = '1;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;      // 0: host wins next contention, 1: solver
  logic              gnt_q, gnt_d;    // requester owning the current access
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic              din_q, din_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              hdout_q, hdout_d;
  logic              sdout_q, sdout_d;
  logic              pick_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      din_q   <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      hdout_q <= 1'b0;
      sdout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hdout_q <= hdout_d;
      sdout_q <= sdout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hdout_d = hdout_q;
    sdout_d = sdout_q;
    pick_s  = 1'b0;

    hAck    = 1'b0;
    sAck    = 1'b0;
    hDout   = hdout_q;
    sDout   = sdout_q;
    clrDone = 1'b0;
    memLoc  = '0;
    memRd   = 1'b0;
    memWr   = 1'b0;
    memDin  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clr || pend_q) begin
          state_d = StClear;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (hReq || sReq) begin
          if (hReq && sReq) begin
            pick_s = rr_q;
            rr_d   = ~rr_q;
          end else begin
            pick_s = sReq;
          end
          gnt_d   = pick_s;
          addr_d  = pick_s ? sAddr : hAddr;
          wr_d    = pick_s ? sWr   : hWr;
          din_d   = pick_s ? sDin  : hDin;
          state_d = StAccess;
        end
      end

      StAccess: begin
        memLoc  = addr_q;
        memRd   = ~wr_q;
        memWr   = wr_q;
        memDin  = wr_q & din_q;
        if (clr) pend_d = 1'b1;
        state_d = StResp;
      end

      StResp: begin
        if (clr) pend_d = 1'b1;
        // Read data is passed straight through this cycle and held afterwards.
        if (gnt_q) begin
          sAck = 1'b1;
          if (!wr_q) begin
            sDout   = memDout;
            sdout_d = memDout;
          end
        end else begin
          hAck = 1'b1;
          if (!wr_q) begin
            hDout   = memDout;
            hdout_d = memDout;
          end
        end
        state_d = StIdle;
      end

      StClear: begin
        // clr is deliberately ignored here; a clear is already in progress.
        memWr  = 1'b1;
        memLoc = cnt_q;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          clrDone = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign clrBusy = pend_q | (state_q == StClear);

  rd_wr_exclusive_a: assert property (@(posedge clk) disable iff (!rst) !(memRd && memWr));

endmodule
